// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-port, MDU-result, scoreboard and hazard signals of the register-file arbiter
interface regfile_wb_arbiter_if;
  logic        wa_valid;
  logic [4:0]  wa_rn;
  logic [31:0] wa_d;
  logic        mb_valid;
  logic [4:0]  mb_rn;
  logic [31:0] mb_d;
  logic        mb_ready;
  logic        sb_set;
  logic [4:0]  sb_rn;
  logic [4:0]  hz_rs;
  logic [4:0]  hz_rt;
  logic [4:0]  hz_rd;
  logic        hz_stall;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic [31:0] sb_busy;
  modport master (
    output wa_valid, wa_rn, wa_d, mb_valid, mb_rn, mb_d, sb_set, sb_rn, hz_rs, hz_rt, hz_rd,
    input  mb_ready, hz_stall, wb_hold, rf_we, rf_wn, rf_d, sb_busy
  );
  modport slave (
    input  wa_valid, wa_rn, wa_d, mb_valid, mb_rn, mb_d, sb_set, sb_rn, hz_rs, hz_rt, hz_rd,
    output mb_ready, hz_stall, wb_hold, rf_we, rf_wn, rf_d, sb_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between WB and a FIFO-buffered MDU, with scoreboard
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 clrn,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    rn_q [DEPTH];
  logic [31:0]   d_q  [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   busy_q, busy_d, set_m, clr_m;
  logic [SW-1:0] st_q, st_d;
  logic          a_win, b_win, ready, push, pop;
  logic [4:0]    head_rn;
  always_comb begin
    head_rn = rn_q[rd_q];
    a_win   = bus.wa_valid && bus.wa_rn != 5'd0;
    b_win   = !a_win && cnt_q != '0;
    ready   = cnt_q < (PW+1)'(DEPTH);
    push    = bus.mb_valid && ready;
    pop     = b_win;
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    set_m   = (bus.sb_set && bus.sb_rn != 5'd0) ? 32'd1 << bus.sb_rn : 32'd0;
    clr_m   = (pop && head_rn != 5'd0) ? 32'd1 << head_rn : 32'd0;
    busy_d  = (busy_q & ~clr_m) | set_m;
    st_d    = (cnt_q == '0 || b_win) ? '0 : (st_q == SW'(STARVE_LIMIT)) ? st_q : st_q + SW'(1);
  end
  always_comb begin
    bus.mb_ready = ready;
    bus.rf_we    = a_win || (b_win && head_rn != 5'd0);
    bus.rf_wn    = a_win ? bus.wa_rn : b_win ? head_rn : 5'd0;
    bus.rf_d     = a_win ? bus.wa_d : b_win ? d_q[rd_q] : 32'd0;
    bus.hz_stall = busy_q[bus.hz_rs] | busy_q[bus.hz_rt] | busy_q[bus.hz_rd];
    bus.wb_hold  = st_q == SW'(STARVE_LIMIT);
    bus.sb_busy  = busy_q;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      busy_q <= '0;
      st_q   <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      st_q   <= st_d;
    end
  end
  // payload storage needs no reset: an entry is only read while counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      rn_q[wr_q] <= bus.mb_rn;
      d_q[wr_q]  <= bus.mb_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench; accepted MDU results are queued and compared as they are granted
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  typedef struct packed { logic [4:0] rn; logic [31:0] d; } ent_t;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  ent_t bq[$];
  ent_t h;
  logic [31:0] busy_m;
  int st_m;
  logic rdy;
  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (.clk(clk), .clrn(clrn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!clrn) begin
      bq.delete();
      busy_m = '0;
      st_m = 0;
    end else begin
      rdy = bq.size() < DEPTH;
      chk("mb_ready", {31'd0, bus.mb_ready}, {31'd0, rdy});
      chk("sb_busy", bus.sb_busy, busy_m);
      chk("hz_stall", {31'd0, bus.hz_stall}, {31'd0, busy_m[bus.hz_rs] | busy_m[bus.hz_rt] | busy_m[bus.hz_rd]});
      chk("wb_hold", {31'd0, bus.wb_hold}, {31'd0, st_m == 4});
      if (bus.wa_valid && bus.wa_rn != 5'd0) begin
        chk("a_we", {31'd0, bus.rf_we}, 32'd1);
        chk("a_wn", {27'd0, bus.rf_wn}, {27'd0, bus.wa_rn});
        chk("a_d", bus.rf_d, bus.wa_d);
        st_m = bq.size() == 0 ? 0 : (st_m < 4 ? st_m + 1 : st_m);
      end else if (bq.size() != 0) begin
        h = bq.pop_front();
        chk("b_we", {31'd0, bus.rf_we}, {31'd0, h.rn != 5'd0});
        chk("b_wn", {27'd0, bus.rf_wn}, {27'd0, h.rn});
        chk("b_d", bus.rf_d, h.d);
        if (h.rn != 5'd0) busy_m[h.rn] = 1'b0;
        st_m = 0;
      end else begin
        chk("idle_we", {31'd0, bus.rf_we}, 32'd0);
        chk("idle_wn", {27'd0, bus.rf_wn}, 32'd0);
        chk("idle_d", bus.rf_d, 32'd0);
        st_m = 0;
      end
      if (bus.sb_set && bus.sb_rn != 5'd0) busy_m[bus.sb_rn] = 1'b1;
      if (bus.mb_valid && rdy) bq.push_back('{bus.mb_rn, bus.mb_d});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wa(input logic v, input logic [4:0] rn, input logic [31:0] d);
    bus.wa_valid = v;
    bus.wa_rn = rn;
    bus.wa_d = d;
  endtask
  task automatic sb(input logic v, input logic [4:0] rn);
    bus.sb_set = v;
    bus.sb_rn = rn;
  endtask
  task automatic push_b(input logic [4:0] rn, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    bus.mb_valid = 1'b1;
    bus.mb_rn = rn;
    bus.mb_d = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.mb_ready;
      tick();
    end
    chk("push_accept", {31'd0, acc}, 32'd1);
    bus.mb_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    wa(0, 0, 0);
    sb(0, 0);
    bus.mb_valid = 0; bus.mb_rn = 0; bus.mb_d = 0;
    bus.hz_rs = 0; bus.hz_rt = 0; bus.hz_rd = 0;
    repeat (2) tick();
    clrn = 1'b1;
    tick();
    wa(1, 5, 32'hDEADBEEF);
    tick();
    wa(0, 0, 0);
    tick();
    wa(1, 1, 32'h11);
    push_b(7, 32'h77);
    wa(1, 3, 32'h33);
    tick();
    wa(0, 0, 0);
    repeat (2) tick();
    sb(1, 9);
    tick();
    sb(0, 0);
    bus.hz_rs = 9;
    tick();
    bus.hz_rs = 0; bus.hz_rt = 9;
    tick();
    bus.hz_rt = 0; bus.hz_rd = 9;
    tick();
    bus.hz_rd = 0; bus.hz_rs = 9;
    push_b(9, 32'h99);
    repeat (2) tick();
    sb(1, 9);
    tick();
    sb(0, 0);
    push_b(9, 32'h9A);
    sb(1, 9);
    tick();
    sb(0, 0);
    tick();
    push_b(9, 32'h9B);
    repeat (2) tick();
    bus.hz_rs = 0;
    wa(1, 2, 32'hA0);
    push_b(1, 32'd1);
    push_b(2, 32'd2);
    bus.mb_valid = 1; bus.mb_rn = 3; bus.mb_d = 32'd3;
    repeat (5) tick();
    wa(0, 0, 0);
    push_b(3, 32'd3);
    push_b(4, 32'd4);
    push_b(0, 32'd5);
    push_b(6, 32'd6);
    push_b(7, 32'd7);
    repeat (3) tick();
    wa(1, 4, 32'h44);
    push_b(8, 32'h88);
    repeat (5) tick();
    wa(1, 0, 32'h5A5A);
    tick();
    wa(0, 0, 0);
    repeat (2) tick();
    sb(1, 12);
    tick();
    sb(0, 0);
    wa(1, 5, 32'h55);
    push_b(10, 32'hA);
    push_b(11, 32'hB);
    wa(0, 0, 0);
    clrn = 1'b0;
    #2;
    chk("rst_ready", {31'd0, bus.mb_ready}, 32'd1);
    chk("rst_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_busy", bus.sb_busy, 32'd0);
    chk("rst_hold", {31'd0, bus.wb_hold}, 32'd0);
    chk("rst_wn", {27'd0, bus.rf_wn}, 32'd0);
    tick();
    clrn = 1'b1;
    repeat (3) tick();
    chk("drain", bq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
